crc_serial_engine: RTL and testbench

- Parametrised bit-serial CRC generator; successor to the fixed 5-bit/4-bit-input CRC block.
- Adds configurable CRC width, polynomial, input width, init value, output XOR and bit order.
- Adds a start/busy/done handshake and back-to-back operation.
- Sits between a word-parallel data source and a framing/checking stage; one input bit is processed per clock.

---
 rtl/crc_serial_engine.sv | 116 +++++++++++
 tb/tb_crc_serial_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine: latches one DATA_W word on start, shifts it through a
// CRC_W-bit LFSR one bit per clock, then presents (register ^ XOR_OUT) on crc_out.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for start; crc_out holds the last result
// ST_SHIFT | consuming one latched data bit per cycle, busy high
// ST_DONE  | one-cycle done pulse; start here begins the next word immediately
module crc_serial_engine #(
    parameter int               CRC_W     = 5,
    parameter logic [CRC_W-1:0] POLY      = 5'h05,
    parameter int               DATA_W    = 4,
    parameter logic [CRC_W-1:0] INIT      = '0,
    parameter logic [CRC_W-1:0] XOR_OUT   = '0,
    parameter bit               LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [CRC_W-1:0]  crc_out
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [CRC_W-1:0]  crc_out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] latch_q, latch_d;

    logic [DATA_W-1:0] latch_aligned;
    logic              bit_in;
    logic              feedback;
    logic [CRC_W-1:0]  crc_stepped;

    // Shifting the latch by the counter moves the current bit to a fixed end,
    // which avoids a variable index whose width differs from the latch range.
    assign latch_aligned = LSB_FIRST ? (latch_q >> cnt_q) : (latch_q << cnt_q);
    assign bit_in        = LSB_FIRST ? latch_aligned[0] : latch_aligned[DATA_W-1];
    assign feedback      = crc_q[CRC_W-1] ^ bit_in;
    assign crc_stepped   = {crc_q[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            crc_q   <= '0;
            cnt_q   <= '0;
            latch_q <= '0;
            crc_out <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            crc_out <= crc_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        crc_out_d = crc_out;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch_d = data_in;
                    crc_d   = INIT;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy  = 1'b1;
                crc_d = crc_stepped;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    crc_out_d = crc_stepped ^ XOR_OUT;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    latch_d = data_in;
                    crc_d   = INIT;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench for crc_serial_engine: several parameterisations driven with
// directed and random words, checked against a polynomial-division reference.
module tb_crc_serial_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, start8, start1;
    logic [3:0]  data_in;
    logic [7:0]  data8;
    logic [0:0]  data1;

    wire [3:0]  busy_v, done_v;
    wire [19:0] crc_flat;
    wire        busy8, done8, busy1, done1;
    wire [7:0]  crc8;
    wire [4:0]  crc1;

    int total = 0;
    int bad   = 0;

    crc_serial_engine u_def (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_v[0]), .done(done_v[0]), .crc_out(crc_flat[4:0]));
    crc_serial_engine #(.LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_v[1]), .done(done_v[1]), .crc_out(crc_flat[9:5]));
    crc_serial_engine #(.INIT(5'h1F)) u_init (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_v[2]), .done(done_v[2]), .crc_out(crc_flat[14:10]));
    crc_serial_engine #(.XOR_OUT(5'h1F)) u_xor (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(busy_v[3]), .done(done_v[3]), .crc_out(crc_flat[19:15]));
    crc_serial_engine #(.CRC_W(8), .POLY(8'h07), .DATA_W(8)) u_crc8 (
        .clk(clk), .reset(reset), .start(start8), .data_in(data8),
        .busy(busy8), .done(done8), .crc_out(crc8));
    crc_serial_engine #(.DATA_W(1)) u_w1 (
        .clk(clk), .reset(reset), .start(start1), .data_in(data1),
        .busy(busy1), .done(done1), .crc_out(crc1));

    // CRC = (M(x)*x^W + INIT(x)*x^D) mod G(x), first-shifted bit as highest degree.
    function automatic logic [7:0] ref_crc(input int w, input logic [7:0] poly, input int dw,
                                           input logic [7:0] data, input logic [7:0] init,
                                           input logic [7:0] xo, input bit lsb);
        logic [31:0] v, msg, g;
        msg = '0;
        for (int i = 0; i < dw; i++) msg[i] = lsb ? data[dw-1-i] : data[i];
        v = (32'(init) << dw) ^ (msg << w);
        g = (32'd1 << w) | 32'(poly);
        for (int i = dw + w - 1; i >= w; i--)
            if (v[i]) v = v ^ (g << (i - w));
        return v[7:0] ^ xo;
    endfunction

    function automatic logic [4:0] exp4(input int k, input logic [3:0] d);
        logic [7:0] r;
        case (k)
            0:       r = ref_crc(5, 8'h05, 4, 8'(d), 8'h00, 8'h00, 1'b0);
            1:       r = ref_crc(5, 8'h05, 4, 8'(d), 8'h00, 8'h00, 1'b1);
            2:       r = ref_crc(5, 8'h05, 4, 8'(d), 8'h1F, 8'h00, 1'b0);
            default: r = ref_crc(5, 8'h05, 4, 8'(d), 8'h00, 8'h1F, 1'b0);
        endcase
        return r[4:0];
    endfunction

    // Advances negedge by negedge until the selected engine shows done (bounded).
    task automatic wait_done(input int which, output int cyc, output int busy_cnt);
        logic d, b;
        cyc = 0;
        busy_cnt = 0;
        forever begin
            case (which)
                0:       begin d = done_v[0]; b = busy_v[0]; end
                1:       begin d = done8;     b = busy8;     end
                default: begin d = done1;     b = busy1;     end
            endcase
            if (d === 1'b1 || cyc >= 30) break;
            if (b === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic issue4(input logic [3:0] d);
        start = 1'b1;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
        data_in = 4'($urandom);
    endtask

    task automatic test_reset;
        total++; if (busy_v !== 4'b0 || done_v !== 4'b0) begin bad++;
            $display("FAIL reset_flags busy=%b done=%b exp 0", busy_v, done_v); end
        total++; if (crc_flat !== 20'h0) begin bad++;
            $display("FAIL reset_crc got=%h exp 0", crc_flat); end
        total++; if ({busy8, done8, crc8, busy1, done1, crc1} !== 16'h0) begin bad++;
            $display("FAIL reset_other got=%h exp 0", {busy8, done8, crc8, busy1, done1, crc1}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy_v !== 4'b0 || done_v !== 4'b0 || crc_flat !== 20'h0) begin bad++;
            $display("FAIL idle_after_reset busy=%b done=%b crc=%h", busy_v, done_v, crc_flat); end
    endtask

    task automatic test_handshake;
        int cyc, bcnt;
        logic [19:0] held;
        issue4(4'b1000);
        wait_done(0, cyc, bcnt);
        total++; if (cyc != 4) begin bad++;
            $display("FAIL latency got=%0d exp=4", cyc); end
        total++; if (bcnt != 4) begin bad++;
            $display("FAIL busy_cycles got=%0d exp=4", bcnt); end
        total++; if (done_v !== 4'b1111 || busy_v !== 4'b0000) begin bad++;
            $display("FAIL done_cycle done=%b busy=%b exp 1111/0000", done_v, busy_v); end
        total++; if (crc_flat[4:0] !== 5'h0D) begin bad++;
            $display("FAIL plan_msb_1000 got=%h exp=0d", crc_flat[4:0]); end
        total++; if (crc_flat[19:15] !== 5'h12) begin bad++;
            $display("FAIL plan_xor_1000 got=%h exp=12", crc_flat[19:15]); end
        held = crc_flat;
        @(negedge clk);
        total++; if (done_v !== 4'b0 || busy_v !== 4'b0) begin bad++;
            $display("FAIL done_one_cycle done=%b busy=%b exp 0", done_v, busy_v); end
        data_in = 4'hF;
        repeat (3) @(negedge clk);
        total++; if (crc_flat !== held) begin bad++;
            $display("FAIL crc_hold got=%h exp=%h", crc_flat, held); end
    endtask

    task automatic test_directed;
        int cyc, bcnt;
        issue4(4'b0001);
        wait_done(0, cyc, bcnt);
        total++; if (crc_flat[4:0] !== 5'h05 || crc_flat[9:5] !== 5'h0D) begin bad++;
            $display("FAIL plan_0001 msb=%h lsb=%h exp 05/0d", crc_flat[4:0], crc_flat[9:5]); end
        @(negedge clk);
        issue4(4'b0000);
        wait_done(0, cyc, bcnt);
        total++; if (crc_flat[14:10] !== 5'h06) begin bad++;
            $display("FAIL plan_init_0000 got=%h exp=06", crc_flat[14:10]); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int cyc, bcnt;
        logic [3:0] d;
        for (int n = 0; n < 24; n++) begin
            d = 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue4(d);
            wait_done(0, cyc, bcnt);
            total++; if (cyc != 4 || bcnt != 4) begin bad++;
                $display("FAIL rand_timing data=%h cyc=%0d busy=%0d exp 4/4", d, cyc, bcnt); end
            for (int k = 0; k < 4; k++) begin
                total++; if (crc_flat[5*k +: 5] !== exp4(k, d)) begin bad++;
                    $display("FAIL rand_crc inst=%0d data=%h got=%h exp=%h",
                             k, d, crc_flat[5*k +: 5], exp4(k, d)); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int c1, c2, b;
        start = 1'b1;
        data_in = 4'b1000;
        @(negedge clk);
        data_in = 4'b0001;
        wait_done(0, c1, b);
        total++; if (c1 != 4 || crc_flat[4:0] !== 5'h0D) begin bad++;
            $display("FAIL b2b_first cyc=%0d crc=%h exp 4/0d", c1, crc_flat[4:0]); end
        for (int k = 0; k < 4; k++) begin
            total++; if (crc_flat[5*k +: 5] !== exp4(k, 4'b1000)) begin bad++;
                $display("FAIL b2b_first_inst inst=%0d got=%h exp=%h",
                         k, crc_flat[5*k +: 5], exp4(k, 4'b1000)); end
        end
        @(negedge clk);
        start = 1'b0;
        data_in = 4'hA;
        total++; if (busy_v !== 4'b1111 || done_v !== 4'b0) begin bad++;
            $display("FAIL b2b_no_gap busy=%b done=%b exp 1111/0000", busy_v, done_v); end
        wait_done(0, c2, b);
        total++; if (c2 + 1 != 5) begin bad++;
            $display("FAIL b2b_spacing got=%0d exp=5", c2 + 1); end
        for (int k = 0; k < 4; k++) begin
            total++; if (crc_flat[5*k +: 5] !== exp4(k, 4'b0001)) begin bad++;
                $display("FAIL b2b_second inst=%0d got=%h exp=%h",
                         k, crc_flat[5*k +: 5], exp4(k, 4'b0001)); end
        end
        @(negedge clk);
        total++; if (busy_v !== 4'b0 || done_v !== 4'b0) begin bad++;
            $display("FAIL b2b_to_idle busy=%b done=%b exp 0", busy_v, done_v); end
    endtask

    task automatic test_ignore_start;
        int cyc, bcnt;
        issue4(4'b1000);
        start = 1'b1; data_in = 4'b1111;
        @(negedge clk);
        start = 1'b0; data_in = 4'b0110;
        @(negedge clk);
        start = 1'b1; data_in = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, cyc, bcnt);
        total++; if (cyc != 1 || crc_flat[4:0] !== 5'h0D) begin bad++;
            $display("FAIL ignore_start cyc=%0d crc=%h exp 1/0d", cyc, crc_flat[4:0]); end
        @(negedge clk);
        total++; if (busy_v !== 4'b0 || done_v !== 4'b0) begin bad++;
            $display("FAIL ignore_start_idle busy=%b done=%b exp 0", busy_v, done_v); end
    endtask

    task automatic test_mid_reset;
        int cyc, bcnt, dones;
        issue4(4'b1000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy_v !== 4'b0 || done_v !== 4'b0 || crc_flat !== 20'h0) begin bad++;
            $display("FAIL mid_reset busy=%b done=%b crc=%h exp all 0", busy_v, done_v, crc_flat); end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v !== 4'b0 || busy_v !== 4'b0) dones++;
        end
        total++; if (dones != 0) begin bad++;
            $display("FAIL mid_reset_abort got=%0d activity cycles exp=0", dones); end
        issue4(4'b1000);
        wait_done(0, cyc, bcnt);
        total++; if (cyc != 4 || crc_flat[4:0] !== 5'h0D) begin bad++;
            $display("FAIL after_reset cyc=%0d crc=%h exp 4/0d", cyc, crc_flat[4:0]); end
        @(negedge clk);
    endtask

    task automatic test_crc8;
        int cyc, bcnt;
        logic [7:0] d, e;
        start8 = 1'b1; data8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0; data8 = 8'hFF;
        wait_done(1, cyc, bcnt);
        total++; if (cyc != 8 || bcnt != 8 || crc8 !== 8'h07) begin bad++;
            $display("FAIL crc8_plan cyc=%0d busy=%0d crc=%h exp 8/8/07", cyc, bcnt, crc8); end
        @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            e = ref_crc(8, 8'h07, 8, d, 8'h00, 8'h00, 1'b0);
            start8 = 1'b1; data8 = d;
            @(negedge clk);
            start8 = 1'b0; data8 = 8'($urandom);
            wait_done(1, cyc, bcnt);
            total++; if (cyc != 8 || crc8 !== e) begin bad++;
                $display("FAIL crc8_rand data=%h cyc=%0d got=%h exp=%h", d, cyc, crc8, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_single_bit;
        int cyc, bcnt;
        logic [7:0] e;
        for (int n = 0; n < 6; n++) begin
            data1 = (n < 2) ? 1'(n) : 1'($urandom);
            e = ref_crc(5, 8'h05, 1, 8'(data1), 8'h00, 8'h00, 1'b0);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            wait_done(2, cyc, bcnt);
            total++; if (cyc != 1 || bcnt != 1 || crc1 !== e[4:0]) begin bad++;
                $display("FAIL w1 data=%b cyc=%0d busy=%0d got=%h exp=1/1/%h",
                         data1, cyc, bcnt, crc1, e[4:0]); end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; start8 = 1'b0; start1 = 1'b0;
        data_in = '0; data8 = '0; data1 = '0;
        repeat (3) @(negedge clk);
        test_reset;
        test_handshake;
        test_directed;
        test_random;
        test_back_to_back;
        test_ignore_start;
        test_mid_reset;
        test_crc8;
        test_single_bit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
